// File: rtl/usr_shift_sequencer.sv
// Command sequencer for the universal shift register: turns LOAD/SHR/SHL/ROR
// commands into per-cycle MODE/DATAIN drive and returns the resulting contents.
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_datain,
  input  logic [WIDTH-1:0] usr_dataout
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, RSP} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   step;
  logic [IDX_W-1:0]   fill_idx;
  logic               fill_bit;

  // Control path: state and step counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      step      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            step <= '0;
            if (cmd_op == OP_LOAD) begin
              remaining <= CNT_W'(1);
              state     <= RUN;
            end else if (cmd_count != '0) begin
              remaining <= cmd_count;
              state     <= RUN;
            end else begin
              state <= RSP;
            end
          end
        end
        RUN: begin
          remaining <= remaining - CNT_W'(1);
          step      <= step + CNT_W'(1);
          if (remaining == CNT_W'(1)) state <= RSP;
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command payload is only meaningful once accepted, so it carries no reset
  always_ff @(posedge clock) begin
    if (state == IDLE && cmd_valid) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
    end
  end

  // Fill bits cycle through cmd_data when the count exceeds the register width
  assign fill_idx = IDX_W'(32'(step) % WIDTH);
  assign fill_bit = data_q[fill_idx];

  always_comb begin
    cmd_ready  = (state == IDLE);
    rsp_valid  = (state == RSP);
    usr_mode   = MODE_HOLD;
    usr_datain = '0;
    if (state == RUN) begin
      case (op_q)
        OP_LOAD: begin
          usr_mode   = MODE_LOAD;
          usr_datain = data_q;
        end
        OP_SHR: begin
          usr_mode   = MODE_SHR;
          usr_datain = {{(WIDTH-1){1'b0}}, fill_bit};
        end
        OP_SHL: begin
          usr_mode   = MODE_SHL;
          usr_datain = {{(WIDTH-1){1'b0}}, fill_bit};
        end
        OP_ROR: begin
          // Rotate feeds the current LSB straight back in as the shift-right fill
          usr_mode   = MODE_SHR;
          usr_datain = {{(WIDTH-1){1'b0}}, usr_dataout[0]};
        end
        default: begin
          usr_mode   = MODE_HOLD;
          usr_datain = '0;
        end
      endcase
    end
  end

  // Mode is hold in RSP, so the register output is stable for the consumer
  assign rsp_data = usr_dataout;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a behavioural 4-bit USR attached
// and a queue of expected responses.
module tb_usr_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic [2:0] cmd_count = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic [1:0] usr_mode;
  logic [3:0] usr_datain;
  logic [3:0] usr_q;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] exp_q[$];

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .usr_mode(usr_mode), .usr_datain(usr_datain), .usr_dataout(usr_q)
  );

  always #5 clock = ~clock;

  // Behavioural USR: serial fill enters through DATAIN[0]
  always @(posedge clock) begin
    if (reset) usr_q <= 4'h0;
    else begin
      case (usr_mode)
        2'b01: usr_q <= {usr_datain[0], usr_q[3:1]};
        2'b10: usr_q <= {usr_q[2:0], usr_datain[0]};
        2'b11: usr_q <= usr_datain;
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Offer a command while idle; returns in cycle 1 after the accepting edge
  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                      input bit expect_rsp, input logic [3:0] exp);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    if (expect_rsp) exp_q.push_back(exp);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    logic [3:0] exp;
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      check({tag, "_timeout"}, 8'(rsp_valid), 8'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 8'(exp_q.size()), 8'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 8'(rsp_data), 8'(exp));
    end
  endtask

  // Full command with rsp_ready held high; returns in the idle cycle afterwards
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] cnt, input logic [3:0] exp);
    rsp_ready = 1'b1;
    send(op, data, cnt, 1'b1, exp);
    wait_rsp(tag);
    tick();
  endtask

  initial begin
    int seen;
    tick();
    tick();
    reset = 1'b0;
    check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    check("rst_usr_mode", 8'(usr_mode), 8'd0);
    check("rst_usr_datain", 8'(usr_datain), 8'd0);

    // LOAD 1010 with cycle-accurate timing
    rsp_ready = 1'b1;
    send(2'b00, 4'b1010, 3'd0, 1'b1, 4'b1010);
    check("load_c1_mode", 8'(usr_mode), 8'h3);
    check("load_c1_datain", 8'(usr_datain), 8'hA);
    check("load_c1_cmd_ready", 8'(cmd_ready), 8'd0);
    check("load_c1_rsp_valid", 8'(rsp_valid), 8'd0);
    tick();
    check("load_c2_rsp_valid", 8'(rsp_valid), 8'd1);
    wait_rsp("load_rsp");
    tick();
    check("load_c3_cmd_ready", 8'(cmd_ready), 8'd1);

    // SHR 2 from zero: fills 1 then 0
    do_reset();
    send(2'b01, 4'b0001, 3'd2, 1'b1, 4'b0100);
    check("shr_c1_mode", 8'(usr_mode), 8'h1);
    check("shr_c1_fill", 8'(usr_datain), 8'h1);
    tick();
    check("shr_c2_fill", 8'(usr_datain), 8'h0);
    tick();
    check("shr_c3_rsp_valid", 8'(rsp_valid), 8'd1);
    wait_rsp("shr2_rsp");
    tick();

    // SHL 3 from zero: fills 1, 0, 1
    do_reset();
    send(2'b10, 4'b0101, 3'd3, 1'b1, 4'b0101);
    check("shl_c1_mode", 8'(usr_mode), 8'h2);
    check("shl_c1_fill", 8'(usr_datain), 8'h1);
    wait_rsp("shl3_rsp");
    tick();

    // Rotates
    run_cmd("ror_pre_load", 2'b00, 4'b1010, 3'd0, 4'b1010);
    run_cmd("ror1_rsp", 2'b11, 4'b0000, 3'd1, 4'b0101);
    run_cmd("ror5_pre_load", 2'b00, 4'b0011, 3'd0, 4'b0011);
    run_cmd("ror5_rsp", 2'b11, 4'b0000, 3'd5, 4'b1001);

    // SHL with count beyond width reuses fill bits cyclically: 1,0,0,0,1,0,0
    do_reset();
    run_cmd("shl7_rsp", 2'b10, 4'b0001, 3'd7, 4'b0100);

    // Count 0 leaves the USR untouched and answers in cycle 1
    run_cmd("cnt0_pre_load", 2'b00, 4'b0110, 3'd0, 4'b0110);
    rsp_ready = 1'b1;
    send(2'b01, 4'b1111, 3'd0, 1'b1, 4'b0110);
    check("cnt0_c1_mode", 8'(usr_mode), 8'h0);
    check("cnt0_c1_rsp_valid", 8'(rsp_valid), 8'd1);
    wait_rsp("cnt0_rsp");
    tick();

    // Backpressure with a second command pending
    rsp_ready = 1'b0;
    send(2'b00, 4'b0111, 3'd0, 1'b1, 4'b0111);
    tick();
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'b1100;
    cmd_count = 3'd0;
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", 8'(rsp_valid), 8'd1);
      check("bp_rsp_data", 8'(rsp_data), 8'h7);
      check("bp_cmd_ready", 8'(cmd_ready), 8'd0);
      tick();
    end
    wait_rsp("bp_rsp");
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_cmd_ready", 8'(cmd_ready), 8'd1);
    check("bp_idle_hold", 8'(usr_q), 8'h7);
    exp_q.push_back(4'b1100);
    tick();
    cmd_valid = 1'b0;
    check("bp_second_mode", 8'(usr_mode), 8'h3);
    wait_rsp("bp_second_rsp");
    tick();

    // Reset during cycle 2 of SHL 4 drops the command
    do_reset();
    rsp_ready = 1'b1;
    send(2'b10, 4'b1111, 3'd4, 1'b0, 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cmd_ready", 8'(cmd_ready), 8'd1);
    check("mid_rst_rsp_valid", 8'(rsp_valid), 8'd0);
    check("mid_rst_mode", 8'(usr_mode), 8'd0);
    check("mid_rst_datain", 8'(usr_datain), 8'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    check("mid_rst_no_rsp", 8'(seen), 8'd0);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
